// File: rtl/cpu_pkg.sv
// Shared pipeline constants: datapath width, mux fan-in limit and forwarding select codes.
package cpu_pkg;

  localparam int DATA_W      = 32;
  localparam int MUX_NUM_MAX = 8;

  localparam int SEL_REG   = 0;
  localparam int SEL_EXMEM = 1;
  localparam int SEL_MEMWB = 2;

  // Select width for an n-input mux; a 2-input mux still needs one bit.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pipe_mux_reg_mux_n.sv
// Combinational N-to-1 selector over a packed input bus; out-of-range index yields input 0.
module mux_n
  import cpu_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int NUM   = 3,
  localparam int SEL_W = sel_width(NUM)
) (
  input  logic [NUM*WIDTH-1:0] data,
  input  logic [SEL_W-1:0]     sel,
  output logic [WIDTH-1:0]     y
);

  always_comb begin
    y = data[0 +: WIDTH];
    for (int k = 1; k < NUM; k++) begin
      if (sel == SEL_W'(k)) y = data[k*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/pipe_mux_reg.sv
// Registered N-input pipeline mux with stall/flush; the saturating illegal-select
// counter err_cnt_o exists only when PIPE_MUX_ERRCNT_EN is defined.
module pipe_mux_reg
  import cpu_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int NUM   = 3,
  localparam int SEL_W = sel_width(NUM)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM*WIDTH-1:0] data_i,
  input  logic [SEL_W-1:0]     select_i,
  input  logic                 valid_i,
  input  logic                 stall_i,
  input  logic                 flush_i,
  output logic [WIDTH-1:0]     data_o,
  output logic                 valid_o,
  output logic                 sel_err_o
`ifdef PIPE_MUX_ERRCNT_EN
  ,
  output logic [7:0]           err_cnt_o
`endif
);

  if (NUM < 2 || NUM > MUX_NUM_MAX) begin : g_num_range
    $error("pipe_mux_reg: NUM must be in 2..8");
  end

  localparam logic [SEL_W:0] NUM_C = (SEL_W+1)'(NUM);

  logic [WIDTH-1:0] mux_y;
  logic             sel_illegal;
  logic             load;

  mux_n #(.WIDTH(WIDTH), .NUM(NUM)) u_mux (
    .data (data_i),
    .sel  (select_i),
    .y    (mux_y)
  );

  assign sel_illegal = {1'b0, select_i} >= NUM_C;
  assign load        = !flush_i && !stall_i;

  // Flush only kills the slot; data is left as-is since valid_o gates its use.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_o    <= '0;
      valid_o   <= 1'b0;
      sel_err_o <= 1'b0;
    end else if (flush_i) begin
      valid_o   <= 1'b0;
      sel_err_o <= 1'b0;
    end else if (!stall_i) begin
      data_o    <= mux_y;
      valid_o   <= valid_i;
      sel_err_o <= sel_illegal;
    end
  end

`ifdef PIPE_MUX_ERRCNT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_cnt_o <= 8'd0;
    end else if (load && valid_i && sel_illegal && err_cnt_o != 8'hFF) begin
      err_cnt_o <= err_cnt_o + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_mux_reg.sv
// Self-checking bench for pipe_mux_reg: a 3x32 instance and an 8x16 instance sharing
// reset/stall/flush, compared every cycle against a behavioural model plus literal checks.
module tb_pipe_mux_reg;

  logic        clk = 1'b0;
  logic        rst, stall, flush;

  logic [31:0] din [3];
  logic [1:0]  sel;
  logic        valid;
  logic [95:0] din_pk;
  logic [31:0] d1;
  logic        v1, e1;
  logic [7:0]  c1;

  logic [15:0]  din2 [8];
  logic [2:0]   sel2;
  logic         valid2;
  logic [127:0] din2_pk;
  logic [15:0]  d2;
  logic         v2, e2;
  logic [7:0]   c2;

  int checks = 0;
  int errors = 0;

  // model state
  logic [31:0] m_data;
  logic        m_valid, m_err;
  int          m_cnt;
  logic [15:0] m2_data;
  logic        m2_valid;
  bit          started = 1'b0;

  always #5 clk = ~clk;

  always_comb begin
    din_pk = {din[2], din[1], din[0]};
    din2_pk = '0;
    for (int k = 0; k < 8; k++) din2_pk[k*16 +: 16] = din2[k];
  end

  pipe_mux_reg #(.WIDTH(32), .NUM(3)) dut1 (
    .clk_i(clk), .rst_i(rst), .data_i(din_pk), .select_i(sel), .valid_i(valid),
    .stall_i(stall), .flush_i(flush), .data_o(d1), .valid_o(v1), .sel_err_o(e1)
`ifdef PIPE_MUX_ERRCNT_EN
    , .err_cnt_o(c1)
`endif
  );

  pipe_mux_reg #(.WIDTH(16), .NUM(8)) dut2 (
    .clk_i(clk), .rst_i(rst), .data_i(din2_pk), .select_i(sel2), .valid_i(valid2),
    .stall_i(stall), .flush_i(flush), .data_o(d2), .valid_o(v2), .sel_err_o(e2)
`ifdef PIPE_MUX_ERRCNT_EN
    , .err_cnt_o(c2)
`endif
  );

`ifndef PIPE_MUX_ERRCNT_EN
  assign c1 = 8'd0;
  assign c2 = 8'd0;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model advances on each edge from the inputs presented, then outputs are compared.
  always @(posedge clk) begin
    if (rst) begin
      m_data = '0; m_valid = 0; m_err = 0; m_cnt = 0;
      m2_data = '0; m2_valid = 0;
      started = 1'b1;
    end else if (flush) begin
      m_valid = 0; m_err = 0;
      m2_valid = 0;
    end else if (!stall) begin
      m_data  = (int'(sel) < 3) ? din[sel] : din[0];
      m_valid = valid;
      m_err   = int'(sel) >= 3;
      if (valid && int'(sel) >= 3) m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
      m2_data  = din2[sel2];
      m2_valid = valid2;
    end
    #2;
    if (started) begin
      chk("cmp_data1", 64'(d1), 64'(m_data));
      chk("cmp_valid1", 64'(v1), 64'(m_valid));
      chk("cmp_err1", 64'(e1), 64'(m_err));
`ifdef PIPE_MUX_ERRCNT_EN
      chk("cmp_cnt1", 64'(c1), 64'(m_cnt));
      chk("cmp_cnt2", 64'(c2), 64'd0);
`endif
      chk("cmp_data2", 64'(d2), 64'(m2_data));
      chk("cmp_valid2", 64'(v2), 64'(m2_valid));
      chk("cmp_err2", 64'(e2), 64'd0);
    end
  end

  task automatic settle();
    @(posedge clk);
    #3;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1; stall = 0; flush = 0; valid = 0; sel = '0; valid2 = 0; sel2 = '0;
    for (int k = 0; k < 3; k++) din[k] = 32'hDEAD0000 + k;
    for (int k = 0; k < 8; k++) din2[k] = 16'h0;
    settle();
    chk("reset_data", 64'(d1), 64'd0);
    chk("reset_valid", 64'(v1), 64'd0);
    chk("reset_err", 64'(e1), 64'd0);
`ifdef PIPE_MUX_ERRCNT_EN
    chk("reset_cnt", 64'(c1), 64'd0);
`endif

    // select 2 after reset
    @(negedge clk);
    rst = 0;
    din[0] = 32'h11111111; din[1] = 32'h22222222; din[2] = 32'h33333333;
    sel = 2'd2; valid = 1;
    settle();
    chk("sel2_data", 64'(d1), 64'h33333333);
    chk("sel2_valid", 64'(v1), 64'd1);

    // illegal select falls back to input 0
    @(negedge clk);
    sel = 2'd3;
    settle();
    chk("illegal_data", 64'(d1), 64'h11111111);
    chk("illegal_err", 64'(e1), 64'd1);
`ifdef PIPE_MUX_ERRCNT_EN
    chk("illegal_cnt", 64'(c1), 64'd1);
`endif

    // load then stall 3 cycles with changing inputs
    @(negedge clk);
    sel = 2'd1;
    settle();
    chk("load_22_data", 64'(d1), 64'h22222222);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      stall = 1;
      sel = 2'($urandom_range(0, 3));
      valid = 1'($urandom);
      for (int k = 0; k < 3; k++) din[k] = $urandom;
      settle();
      chk("stall_data", 64'(d1), 64'h22222222);
      chk("stall_valid", 64'(v1), 64'd1);
    end

    // flush with stall, then flush alone
    @(negedge clk);
    flush = 1; stall = 1; sel = 2'd3; valid = 1;
    settle();
    chk("flush_stall_valid", 64'(v1), 64'd0);
    chk("flush_stall_data", 64'(d1), 64'h22222222);
    @(negedge clk);
    stall = 0;
    settle();
    chk("flush_valid", 64'(v1), 64'd0);
    chk("flush_err", 64'(e1), 64'd0);
    chk("flush_data", 64'(d1), 64'h22222222);
`ifdef PIPE_MUX_ERRCNT_EN
    chk("flush_cnt", 64'(c1), 64'd1);
`endif

    // 300 illegal loads saturate the counter
    @(negedge clk);
    flush = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      sel = 2'd3; valid = 1;
      for (int k = 0; k < 3; k++) din[k] = $urandom;
    end
    settle();
    chk("sat_data", 64'(d1), 64'(din[0]));
    chk("sat_err", 64'(e1), 64'd1);
    chk("sat_model_cnt", 64'(m_cnt), 64'd255);
`ifdef PIPE_MUX_ERRCNT_EN
    chk("sat_cnt", 64'(c1), 64'd255);
`endif
    @(negedge clk);
    rst = 1; stall = 1; flush = 1;
    settle();
    chk("rst_data", 64'(d1), 64'd0);
    chk("rst_valid", 64'(v1), 64'd0);
    chk("rst_err", 64'(e1), 64'd0);
`ifdef PIPE_MUX_ERRCNT_EN
    chk("rst_cnt", 64'(c1), 64'd0);
`endif

    // 8x16 select sweep
    @(negedge clk);
    rst = 0; stall = 0; flush = 0; valid = 0;
    for (int s = 0; s < 8; s++) begin
      @(negedge clk);
      for (int k = 0; k < 8; k++) din2[k] = 16'($urandom);
      sel2 = 3'(s); valid2 = 1;
      settle();
      chk("sweep_data", 64'(d2), 64'(din2[s]));
      chk("sweep_valid", 64'(v2), 64'd1);
    end

    // randomized traffic on both instances
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      rst    = ($urandom_range(0, 99) < 2);
      flush  = ($urandom_range(0, 99) < 10);
      stall  = ($urandom_range(0, 99) < 20);
      valid  = 1'($urandom);
      sel    = 2'($urandom_range(0, 3));
      valid2 = 1'($urandom);
      sel2   = 3'($urandom_range(0, 7));
      for (int k = 0; k < 3; k++) din[k] = $urandom;
      for (int k = 0; k < 8; k++) din2[k] = 16'($urandom);
    end
    @(negedge clk);
    rst = 0; flush = 0; stall = 0;
    settle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
